pipe_ctrl_unit: RTL and testbench
=================================

// Module: pipe_ctrl_unit
// PURPOSE
//  Parametrised pipeline controller for the LC3-class core. Generates the per-stage enables,
//  branch-taken pulse, ALU/MEM operand bypass selects and memory-access state. Generalises the
//  fixed 5-stage control_out bundle: N stages, load-use stall, flush penalty, memory timeout.
//  Sits between decode/execute status and every pipeline stage; the control_out agent monitors it.
// PARAMETERS
//  NUM_STAGES  5   pipeline stages; stage 0 = updatePC, NUM_STAGES-1 = writeback (4..8)
//  EX_STAGE    3   index of execute stage (2..NUM_STAGES-2)
//  REG_AW      3   register-file address width
//  BR_PENALTY  2   cycles stages 1..EX_STAGE-1 are squashed after a taken branch (1..7)
//  MEM_TIMEOUT 15  max wait cycles for complete_data before abort (1..255)
// PORTS
//  clock          in   1           core clock
//  reset          in   1           synchronous, active-high
//  complete_data  in   1           memory access done (1-cycle pulse)
//  dec_sr1/dec_sr2 in  REG_AW      source regs of instr in decode
//  dec_sr1_used/dec_sr2_used in 1  source actually read
//  ex_dr          in   REG_AW      dest reg of instr in execute
//  ex_wr          in   1           execute instr writes ex_dr
//  ex_is_load     in   1           execute instr is LD/LDR/LDI
//  ex_mem_kind    in   2           00 none, 01 read, 10 write, 11 indirect read
//  ex_br          in   1           execute instr is branch and condition true
//  wb_dr          in   REG_AW      dest reg of instr in memory/writeback
//  wb_wr          in   1           that instr writes wb_dr
//  enable         out  NUM_STAGES  per-stage advance enable
//  br_taken       out  1           taken-branch pulse
//  bypass_alu_1/2 out  1           forward execute result to operand 1/2
//  bypass_mem_1/2 out  1           forward memory/writeback result to operand 1/2
//  mem_state      out  2           3 idle, 0 read, 1 indirect-addr read, 2 write
//  mem_err        out  1           sticky: memory timeout occurred
// BEHAVIOUR
//  All outputs registered. Reset: enable=0, br_taken=0, bypass_*=0, mem_state=3, mem_err=0,
//   all counters 0. Reset mid-operation aborts any access/flush/fill immediately.
//  Fill: cycle k after reset release (k=0..) sets enable[0..k]; full enables after NUM_STAGES cycles.
//  Memory FSM (mem_state): IDLE(3) -> on enable[EX_STAGE] & ex_mem_kind!=0: 01->READ(0),
//   10->WRITE(2), 11->IND(1). IND --complete_data--> READ. READ/WRITE --complete_data--> IDLE.
//   While not IDLE: enable[0..NUM_STAGES-1] all 0 (full freeze); enables resume cycle after return.
//   Wait counter cleared on each state entry; reaching MEM_TIMEOUT without complete_data -> IDLE,
//   mem_err=1 (clears only on reset). complete_data in IDLE ignored.
//  Branch: ex_br & enable[EX_STAGE] -> next cycle br_taken=1 for exactly 1 cycle, flush counter
//   loaded with BR_PENALTY; while counter!=0, enable[1..EX_STAGE-1]=0, enable[0]=1 (PC redirect).
//   Branch arriving during a flush reloads counter. Branch with memory access: memory FSM first.
//  Load-use stall: ex_is_load & ex_wr & ((dec_sr1_used & dec_sr1==ex_dr)|(dec_sr2_used &
//   dec_sr2==ex_dr)) -> 1-cycle bubble: enable[0..EX_STAGE-1]=0, later stages enabled.
//   Priority: reset > memory freeze > load-use stall > flush > normal.
//  Bypass: sampled when enable[EX_STAGE-1] (decode advances); hold otherwise.
//   alu_n = dec_srn_used & ex_wr & !ex_is_load & dec_srn==ex_dr;
//   mem_n = dec_srn_used & wb_wr & dec_srn==wb_dr & !alu_n (ALU has priority; never both set).
//  Register address compare is full REG_AW width; no wrap arithmetic on counters (saturate).
// TESTING
//  Reset release, no hazards -> enable 00001,00011,00111,01111,11111 over 5 cycles (default params).
//  ex_br=1 at full pipe -> br_taken=1 one cycle; enable[2:1]=0 for 2 cycles, then 11111.
//  ex_mem_kind=11, complete_data at +3 and +6 -> mem_state 1,1,1,0,0,0,3; enable=0 throughout.
//  ex_mem_kind=01, no complete_data -> mem_state=0 for 15 cycles, then 3, mem_err=1 until reset.
//  ex_is_load, ex_dr=3, dec_sr1=3 -> one cycle enable=11000; ex_dr=3 non-load -> bypass_alu_1=1.
//  ex_dr=wb_dr=5=dec_sr2, both writing -> bypass_alu_2=1, bypass_mem_2=0; reset during READ -> idle.

Source files
------------

// File: rtl/pipe_ctrl_unit_if.sv
// Handshake bundle between the pipeline controller and the core's decode/execute/writeback status.
// The controller takes the master modport; the pipeline (or a bench) takes the slave modport.
interface pipe_ctrl_unit_if #(
    parameter int NUM_STAGES = 5,
    parameter int REG_AW     = 3
);
    // status from the pipeline
    logic                  complete_data;
    logic [REG_AW-1:0]     dec_sr1;
    logic [REG_AW-1:0]     dec_sr2;
    logic                  dec_sr1_used;
    logic                  dec_sr2_used;
    logic [REG_AW-1:0]     ex_dr;
    logic                  ex_wr;
    logic                  ex_is_load;
    logic [1:0]            ex_mem_kind;
    logic                  ex_br;
    logic [REG_AW-1:0]     wb_dr;
    logic                  wb_wr;

    // control back to the pipeline
    logic [NUM_STAGES-1:0] enable;
    logic                  br_taken;
    logic                  bypass_alu_1;
    logic                  bypass_alu_2;
    logic                  bypass_mem_1;
    logic                  bypass_mem_2;
    logic [1:0]            mem_state;
    logic                  mem_err;

    modport master (
        input  complete_data, dec_sr1, dec_sr2, dec_sr1_used, dec_sr2_used,
               ex_dr, ex_wr, ex_is_load, ex_mem_kind, ex_br, wb_dr, wb_wr,
        output enable, br_taken, bypass_alu_1, bypass_alu_2,
               bypass_mem_1, bypass_mem_2, mem_state, mem_err
    );

    modport slave (
        output complete_data, dec_sr1, dec_sr2, dec_sr1_used, dec_sr2_used,
               ex_dr, ex_wr, ex_is_load, ex_mem_kind, ex_br, wb_dr, wb_wr,
        input  enable, br_taken, bypass_alu_1, bypass_alu_2,
               bypass_mem_1, bypass_mem_2, mem_state, mem_err
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipeline controller: per-stage enables (fill, memory freeze, load-use bubble, branch flush),
// taken-branch pulse, operand bypass selects and the memory-access state machine. All outputs registered.
module pipe_ctrl_unit #(
    parameter int NUM_STAGES  = 5,
    parameter int EX_STAGE    = 3,
    parameter int REG_AW      = 3,
    parameter int BR_PENALTY  = 2,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic           clock,
    input  logic           reset,
    pipe_ctrl_unit_if.master ctl
);

    localparam int FW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    typedef enum logic [1:0] {
        MEM_READ  = 2'd0,
        MEM_IND   = 2'd1,
        MEM_WRITE = 2'd2,
        MEM_IDLE  = 2'd3
    } mem_state_e;

    mem_state_e            mem_state_q, mem_state_d;
    logic [7:0]            wait_q, wait_d;
    logic [2:0]            flush_q, flush_d;
    logic [FW-1:0]         fill_q, fill_d;
    logic                  mem_err_q, mem_err_d;
    logic [NUM_STAGES-1:0] enable_q, enable_d;
    logic                  br_taken_q, br_taken_d;
    logic [1:0]            byp_alu_q, byp_alu_d;
    logic [1:0]            byp_mem_q, byp_mem_d;

    logic                  mem_start;
    logic                  br_accept;
    logic                  load_use;
    logic                  frozen;
    logic [NUM_STAGES-1:0] fill_mask;
    logic [REG_AW-1:0]     dec_sr [2];
    logic [1:0]            dec_used;
    logic [1:0]            alu_hit;
    logic [1:0]            mem_hit;
    logic [1:0]            load_hit;

    assign dec_sr[0]   = ctl.dec_sr1;
    assign dec_sr[1]   = ctl.dec_sr2;
    assign dec_used[0] = ctl.dec_sr1_used;
    assign dec_used[1] = ctl.dec_sr2_used;

    // Stage gi is live once gi cycles have elapsed since reset release.
    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_fill
            assign fill_mask[gi] = (fill_q >= FW'(gi));
        end
    endgenerate

    // ALU forwarding wins over memory forwarding; a load result is not yet available from the ALU.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            assign alu_hit[gi]  = dec_used[gi] & ctl.ex_wr & ~ctl.ex_is_load & (dec_sr[gi] == ctl.ex_dr);
            assign mem_hit[gi]  = dec_used[gi] & ctl.wb_wr & (dec_sr[gi] == ctl.wb_dr) & ~alu_hit[gi];
            assign load_hit[gi] = dec_used[gi] & (dec_sr[gi] == ctl.ex_dr);
        end
    endgenerate

    assign load_use  = ctl.ex_is_load & ctl.ex_wr & (|load_hit);
    assign mem_start = (mem_state_q == MEM_IDLE) & enable_q[EX_STAGE] & (ctl.ex_mem_kind != 2'b00);
    assign br_accept = ctl.ex_br & enable_q[EX_STAGE] & ~mem_start;
    assign frozen    = (mem_state_d != MEM_IDLE);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_state_q <= MEM_IDLE;
            wait_q      <= '0;
            flush_q     <= '0;
            fill_q      <= '0;
            mem_err_q   <= 1'b0;
            enable_q    <= '0;
            br_taken_q  <= 1'b0;
            byp_alu_q   <= '0;
            byp_mem_q   <= '0;
        end else begin
            mem_state_q <= mem_state_d;
            wait_q      <= wait_d;
            flush_q     <= flush_d;
            fill_q      <= fill_d;
            mem_err_q   <= mem_err_d;
            enable_q    <= enable_d;
            br_taken_q  <= br_taken_d;
            byp_alu_q   <= byp_alu_d;
            byp_mem_q   <= byp_mem_d;
        end
    end

    // Next state: memory FSM, wait/flush/fill counters
    always_comb begin
        mem_state_d = mem_state_q;
        wait_d      = wait_q;
        mem_err_d   = mem_err_q;
        case (mem_state_q)
            MEM_IDLE: begin
                wait_d = '0;
                if (mem_start) begin
                    case (ctl.ex_mem_kind)
                        2'b01:   mem_state_d = MEM_READ;
                        2'b10:   mem_state_d = MEM_WRITE;
                        default: mem_state_d = MEM_IND;
                    endcase
                end
            end
            default: begin
                if (ctl.complete_data) begin
                    mem_state_d = (mem_state_q == MEM_IND) ? MEM_READ : MEM_IDLE;
                    wait_d      = '0;
                end else if (wait_q == 8'(MEM_TIMEOUT - 1)) begin
                    mem_state_d = MEM_IDLE;
                    wait_d      = '0;
                    mem_err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
        endcase

        fill_d = (fill_q == FW'(NUM_STAGES - 1)) ? fill_q : fill_q + 1'b1;

        // The flush window does not elapse while the whole pipe is frozen.
        flush_d = flush_q;
        if (br_accept) begin
            flush_d = 3'(BR_PENALTY);
        end else if (!frozen && flush_q != 3'd0) begin
            flush_d = flush_q - 3'd1;
        end
    end

    // Output next values: freeze > load-use bubble > branch flush > fill/normal
    always_comb begin
        enable_d = fill_mask;
        if (frozen) begin
            enable_d = '0;
        end else if (load_use) begin
            enable_d[EX_STAGE-1:0] = '0;
        end else if (flush_d != 3'd0) begin
            enable_d[EX_STAGE-1:1] = '0;
            enable_d[0]            = 1'b1;
        end

        br_taken_d = br_accept;

        byp_alu_d = byp_alu_q;
        byp_mem_d = byp_mem_q;
        if (enable_q[EX_STAGE-1]) begin
            byp_alu_d = alu_hit;
            byp_mem_d = mem_hit;
        end
    end

    assign ctl.enable       = enable_q;
    assign ctl.br_taken     = br_taken_q;
    assign ctl.bypass_alu_1 = byp_alu_q[0];
    assign ctl.bypass_alu_2 = byp_alu_q[1];
    assign ctl.bypass_mem_1 = byp_mem_q[0];
    assign ctl.bypass_mem_2 = byp_mem_q[1];
    assign ctl.mem_state    = mem_state_q;
    assign ctl.mem_err      = mem_err_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: vector table, hand-written multi-cycle sequences and a randomized
// run checked against a cycle-level reference model of the controller's rules.
module tb_pipe_ctrl_unit;

    localparam int NS  = 5;
    localparam int EX  = 3;
    localparam int AW  = 3;
    localparam int BRP = 2;
    localparam int TMO = 15;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    pipe_ctrl_unit_if #(.NUM_STAGES(NS), .REG_AW(AW)) bus ();

    pipe_ctrl_unit #(
        .NUM_STAGES(NS), .EX_STAGE(EX), .REG_AW(AW),
        .BR_PENALTY(BRP), .MEM_TIMEOUT(TMO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ctl  (bus.master)
    );

    typedef struct {
        logic        rst, cd;
        logic [2:0]  sr1, sr2;
        logic        u1, u2;
        logic [2:0]  exdr;
        logic        exwr, exld;
        logic [1:0]  kind;
        logic        br;
        logic [2:0]  wbdr;
        logic        wbwr;
        logic [4:0]  en;
        logic        ebr;
        logic [3:0]  byp;   // {alu_1, alu_2, mem_1, mem_2}
        logic [1:0]  ms;
        logic        err;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t tbl [14];

    function automatic vec_t mk(int rst, int sr1, int sr2, int u1, int u2, int exdr, int exwr,
                                int exld, int wbdr, int wbwr, int en, int byp);
        vec_t v;
        v.rst  = 1'(rst);  v.cd   = 1'b0;
        v.sr1  = 3'(sr1);  v.sr2  = 3'(sr2);
        v.u1   = 1'(u1);   v.u2   = 1'(u2);
        v.exdr = 3'(exdr); v.exwr = 1'(exwr); v.exld = 1'(exld);
        v.kind = 2'b00;    v.br   = 1'b0;
        v.wbdr = 3'(wbdr); v.wbwr = 1'(wbwr);
        v.en   = 5'(en);   v.ebr  = 1'b0;
        v.byp  = 4'(byp);  v.ms   = 2'd3;  v.err = 1'b0;
        return v;
    endfunction

    function automatic logic [12:0] pk(logic [4:0] en, logic br, logic [3:0] byp, logic [1:0] ms, logic err);
        return {en, br, byp, ms, err};
    endfunction

    function automatic logic [12:0] dut_out();
        return {bus.enable, bus.br_taken, bus.bypass_alu_1, bus.bypass_alu_2,
                bus.bypass_mem_1, bus.bypass_mem_2, bus.mem_state, bus.mem_err};
    endfunction

    task automatic apply(input vec_t v);
        reset            = v.rst;
        bus.complete_data = v.cd;
        bus.dec_sr1      = v.sr1;   bus.dec_sr2      = v.sr2;
        bus.dec_sr1_used = v.u1;    bus.dec_sr2_used = v.u2;
        bus.ex_dr        = v.exdr;  bus.ex_wr        = v.exwr;
        bus.ex_is_load   = v.exld;  bus.ex_mem_kind  = v.kind;
        bus.ex_br        = v.br;
        bus.wb_dr        = v.wbdr;  bus.wb_wr        = v.wbwr;
    endtask

    task automatic clr_in();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [12:0] exp, input bit quiet);
        logic [12:0] act;
        act = dut_out();
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got en=%b br=%b byp=%b ms=%0d err=%b, expected en=%b br=%b byp=%b ms=%0d err=%b",
                     name, act[12:8], act[7], act[6:3], act[2:1], act[0],
                     exp[12:8], exp[7], exp[6:3], exp[2:1], exp[0]);
        end else if (!quiet) begin
            $display("[TB] %s ok: en=%b br=%b byp=%b ms=%0d err=%b",
                     name, act[12:8], act[7], act[6:3], act[2:1], act[0]);
        end
    endtask

    // Reference model state
    int         m_since, m_mem, m_shown, m_flush;
    logic       m_err, m_br;
    logic [4:0] m_en;
    logic [3:0] m_byp;

    task automatic model_step(input vec_t v);
        bit start, br_ok, stall, frozen, en_ex, en_dec, a1, a2;
        if (v.rst) begin
            m_since = 0; m_mem = 3; m_shown = 0; m_flush = 0;
            m_err = 0; m_br = 0; m_en = '0; m_byp = '0;
            return;
        end
        en_ex  = m_en[EX];
        en_dec = m_en[EX-1];
        start  = (m_mem == 3) && en_ex && (v.kind != 0);
        if (m_mem == 3) begin
            if (start) begin
                m_mem   = (v.kind == 1) ? 0 : (v.kind == 2) ? 2 : 1;
                m_shown = 1;
            end
        end else if (v.cd) begin
            m_mem   = (m_mem == 1) ? 0 : 3;
            m_shown = 1;
        end else if (m_shown == TMO) begin
            m_mem = 3;
            m_err = 1;
        end else begin
            m_shown++;
        end
        frozen = (m_mem != 3);
        br_ok  = v.br && en_ex && !start;
        if (br_ok) m_flush = BRP;
        else if (!frozen && m_flush > 0) m_flush--;
        stall = v.exld && v.exwr && ((v.u1 && v.sr1 == v.exdr) || (v.u2 && v.sr2 == v.exdr));
        for (int s = 0; s < NS; s++) begin
            bit live;
            live = (s <= m_since);
            if (frozen)           m_en[s] = 1'b0;
            else if (stall)       m_en[s] = (s >= EX) ? live : 1'b0;
            else if (m_flush > 0) m_en[s] = (s == 0) ? 1'b1 : ((s < EX) ? 1'b0 : live);
            else                  m_en[s] = live;
        end
        m_br = br_ok;
        if (en_dec) begin
            a1 = v.u1 && v.exwr && !v.exld && (v.sr1 == v.exdr);
            a2 = v.u2 && v.exwr && !v.exld && (v.sr2 == v.exdr);
            m_byp = {a1, a2,
                     v.u1 && v.wbwr && (v.sr1 == v.wbdr) && !a1,
                     v.u2 && v.wbwr && (v.sr2 == v.wbdr) && !a2};
        end
        m_since++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        vec_t v;
        logic [4:0] en_exp;

        //            rst sr1 sr2 u1 u2 exdr wr ld wbdr wbwr  en       byp
        tbl[0]  = mk(1,  0,  0,  0, 0, 0,   0, 0, 0,   0,   5'b00000, 4'b0000);
        tbl[1]  = mk(0,  0,  0,  0, 0, 0,   0, 0, 0,   0,   5'b00001, 4'b0000);
        tbl[2]  = mk(0,  0,  0,  0, 0, 0,   0, 0, 0,   0,   5'b00011, 4'b0000);
        tbl[3]  = mk(0,  0,  0,  0, 0, 0,   0, 0, 0,   0,   5'b00111, 4'b0000);
        tbl[4]  = mk(0,  0,  0,  0, 0, 0,   0, 0, 0,   0,   5'b01111, 4'b0000);
        tbl[5]  = mk(0,  0,  0,  0, 0, 0,   0, 0, 0,   0,   5'b11111, 4'b0000);
        tbl[6]  = mk(0,  3,  0,  1, 0, 3,   1, 0, 0,   0,   5'b11111, 4'b1000);
        tbl[7]  = mk(0,  3,  0,  1, 0, 3,   1, 1, 0,   0,   5'b11000, 4'b0000);
        tbl[8]  = mk(0,  0,  5,  0, 1, 5,   1, 0, 0,   0,   5'b11111, 4'b0000);
        tbl[9]  = mk(0,  0,  5,  0, 1, 5,   1, 0, 0,   0,   5'b11111, 4'b0100);
        tbl[10] = mk(0,  0,  5,  0, 1, 5,   1, 0, 5,   1,   5'b11111, 4'b0100);
        tbl[11] = mk(0,  5,  5,  1, 1, 0,   0, 0, 5,   1,   5'b11111, 4'b0011);
        tbl[12] = mk(0,  1,  5,  1, 1, 0,   0, 0, 5,   1,   5'b11111, 4'b0001);
        tbl[13] = mk(0,  5,  5,  0, 0, 5,   1, 0, 5,   1,   5'b11111, 4'b0000);

        reset = 1'b1;
        clr_in();
        reset = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) begin
            apply(tbl[i]);
            tick();
            check($sformatf("vec%0d", i), pk(tbl[i].en, tbl[i].ebr, tbl[i].byp, tbl[i].ms, tbl[i].err), 1'b0);
        end

        // Taken branch at full pipe: one-cycle pulse, stages 1..2 squashed for two cycles
        clr_in();
        bus.ex_br = 1'b1;
        tick(); check("br_pulse",  pk(5'b11001, 1'b1, 4'b0, 2'd3, 1'b0), 1'b0);
        bus.ex_br = 1'b0;
        tick(); check("br_flush2", pk(5'b11001, 1'b0, 4'b0, 2'd3, 1'b0), 1'b0);
        tick(); check("br_done",   pk(5'b11111, 1'b0, 4'b0, 2'd3, 1'b0), 1'b0);

        // Indirect read, completions at +3 and +6
        bus.ex_mem_kind = 2'b11;
        tick(); check("ind_start", pk(5'b00000, 1'b0, 4'b0, 2'd1, 1'b0), 1'b0);
        bus.ex_mem_kind = 2'b00;
        for (int i = 1; i <= 6; i++) begin
            bus.complete_data = (i == 3 || i == 6);
            tick();
            bus.complete_data = 1'b0;
            check($sformatf("ind_c%0d", i),
                  pk((i == 6) ? 5'b11111 : 5'b00000, 1'b0, 4'b0,
                     (i < 3) ? 2'd1 : (i < 6) ? 2'd0 : 2'd3, 1'b0), 1'b0);
        end

        // Read with no completion: 15 cycles in READ, then timeout
        bus.ex_mem_kind = 2'b01;
        tick(); check("tmo_start", pk(5'b00000, 1'b0, 4'b0, 2'd0, 1'b0), 1'b0);
        bus.ex_mem_kind = 2'b00;
        for (int i = 1; i <= 15; i++) begin
            tick();
            check($sformatf("tmo_c%0d", i),
                  (i < 15) ? pk(5'b00000, 1'b0, 4'b0, 2'd0, 1'b0)
                           : pk(5'b11111, 1'b0, 4'b0, 2'd3, 1'b1), 1'b0);
        end
        bus.complete_data = 1'b1;
        tick(); check("idle_cd_ignored", pk(5'b11111, 1'b0, 4'b0, 2'd3, 1'b1), 1'b0);
        bus.complete_data = 1'b0;
        tick(); check("err_sticky", pk(5'b11111, 1'b0, 4'b0, 2'd3, 1'b1), 1'b0);

        // Reset in the middle of a read
        bus.ex_mem_kind = 2'b01;
        tick();
        bus.ex_mem_kind = 2'b00;
        tick(); check("rd_busy", pk(5'b00000, 1'b0, 4'b0, 2'd0, 1'b1), 1'b0);
        reset = 1'b1;
        tick(); check("rd_reset", pk(5'b00000, 1'b0, 4'b0, 2'd3, 1'b0), 1'b0);
        reset = 1'b0;
        tick(); check("refill", pk(5'b00001, 1'b0, 4'b0, 2'd3, 1'b0), 1'b0);

        // Randomized run against the reference model
        for (int i = 0; i < 3000; i++) begin
            v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            v.rst  = (i == 0) || ($urandom_range(0, 199) == 0);
            v.cd   = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
            v.kind = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            v.br   = ($urandom_range(0, 7) == 0);
            v.sr1  = 3'($urandom_range(0, 7));
            v.sr2  = 3'($urandom_range(0, 7));
            v.exdr = 3'($urandom_range(0, 7));
            v.wbdr = 3'($urandom_range(0, 7));
            v.u1   = 1'($urandom_range(0, 1));
            v.u2   = 1'($urandom_range(0, 1));
            v.exwr = 1'($urandom_range(0, 1));
            v.exld = ($urandom_range(0, 3) == 0);
            v.wbwr = 1'($urandom_range(0, 1));
            apply(v);
            model_step(v);
            tick();
            en_exp = m_en;
            check($sformatf("rand%0d", i), pk(en_exp, m_br, m_byp, 2'(m_mem), m_err), 1'b1);
        end
        $display("[TB] random phase complete: 3000 cycles compared against model");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
